sd_spi_responder: RTL



---
 rtl/sd_spi_responder.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: card-side SPI-mode SD model. It oversamples the host SPI
// lines, decodes 48-bit command frames and answers the init/read sequence
// (CMD0, CMD8, CMD55/ACMD41, CMD58, CMD17). A CMD17 block is streamed from a
// byte-wide memory port.
module sd_spi_responder #(
  parameter int          BLOCK_BYTES = 512,
  parameter int          NCR_BYTES   = 1,
  parameter int          NAC_BYTES   = 2,
  parameter int          ACMD41_BUSY = 2,
  parameter logic [31:0] OCR         = 32'hC0FF8000
) (
  input  logic        sdr_clk_i,
  input  logic        sdr_rst_ni,
  input  logic        spi_sck_i,
  input  logic        spi_mosi_i,
  input  logic        spi_cs_ni,
  output logic        spi_miso_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_data_i,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        card_ready_o
);

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_NCR   = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_NAC   = 3'd4;
  localparam logic [2:0] S_TOKEN = 3'd5;
  localparam logic [2:0] S_DATA  = 3'd6;
  localparam logic [2:0] S_CRC   = 3'd7;

  localparam logic [15:0] LP_NCR_LAST   = 16'(NCR_BYTES - 1);
  localparam logic [15:0] LP_NAC_LAST   = 16'(NAC_BYTES - 1);
  localparam logic [15:0] LP_BLOCK_LAST = 16'(BLOCK_BYTES - 1);
  localparam logic [7:0]  LP_BUSY       = 8'(ACMD41_BUSY);

  // Synchronizers
  logic r_sck_meta, r_sck_sync, r_sck_prev;
  logic r_mosi_meta, r_mosi_sync;
  logic r_cs_meta, r_cs_sync;

  // Byte engine and sequencer
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [5:0]  r_index;
  logic [31:0] r_arg;
  logic [39:0] r_resp;
  logic [2:0]  r_resp_len;
  logic        r_data_pending;

  // Card flags
  logic        r_idle_flag;
  logic        r_app_flag;
  logic [7:0]  r_acmd41_cnt;

  // Memory prefetch
  logic        r_fetch_req;
  logic [31:0] r_fetch_addr;
  logic        r_rd_dly;
  logic [7:0]  r_mem_byte;

  logic        w_sck_rise, w_sck_fall, w_cs_active, w_start;
  logic [7:0]  w_rx_byte;
  logic [2:0]  w_next_state;
  logic [15:0] w_next_cnt;
  logic [7:0]  w_next_tx;

  logic [7:0]  w_r1;
  logic [39:0] w_dec_resp;
  logic [2:0]  w_dec_len;
  logic        w_dec_data;
  logic        w_dec_idle;
  logic        w_dec_app;
  logic        w_dec_ready;
  logic [7:0]  w_dec_acnt;

  assign w_sck_rise  = r_sck_sync & ~r_sck_prev;
  assign w_sck_fall  = ~r_sck_sync & r_sck_prev;
  assign w_cs_active = ~r_cs_sync;
  assign w_rx_byte   = {r_rx_shift, r_mosi_sync};
  assign w_start     = (w_rx_byte[7:6] == 2'b01);
  assign w_r1        = {7'd0, r_idle_flag};

  // Bring the asynchronous SPI pins into the system clock domain
  always_ff @(posedge sdr_clk_i or negedge sdr_rst_ni) begin
    if (!sdr_rst_ni) begin
      r_sck_meta  <= 1'b0;
      r_sck_sync  <= 1'b0;
      r_sck_prev  <= 1'b0;
      r_mosi_meta <= 1'b1;
      r_mosi_sync <= 1'b1;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
    end else begin
      r_sck_meta  <= spi_sck_i;
      r_sck_sync  <= r_sck_meta;
      r_sck_prev  <= r_sck_sync;
      r_mosi_meta <= spi_mosi_i;
      r_mosi_sync <= r_mosi_meta;
      r_cs_meta   <= spi_cs_ni;
      r_cs_sync   <= r_cs_meta;
    end
  end

  // Sequencer: phase and byte count of the byte loaded at the next boundary
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt + 16'd1;
    case (r_state)
      S_WAIT: begin
        w_next_cnt = 16'd0;
        if (w_start) w_next_state = S_CMD;
      end
      S_CMD: if (r_cnt == 16'd4) begin
        w_next_state = S_NCR;
        w_next_cnt   = 16'd0;
      end
      S_NCR: if (r_cnt == LP_NCR_LAST) begin
        w_next_state = S_RESP;
        w_next_cnt   = 16'd0;
      end
      S_RESP: if (r_cnt + 16'd1 == {13'd0, r_resp_len}) begin
        w_next_state = r_data_pending ? S_NAC : S_WAIT;
        w_next_cnt   = 16'd0;
      end
      S_NAC: if (r_cnt == LP_NAC_LAST) begin
        w_next_state = S_TOKEN;
        w_next_cnt   = 16'd0;
      end
      S_TOKEN: begin
        w_next_state = S_DATA;
        w_next_cnt   = 16'd0;
      end
      S_DATA: if (r_cnt == LP_BLOCK_LAST) begin
        w_next_state = S_CRC;
        w_next_cnt   = 16'd0;
      end
      default: if (r_cnt == 16'd1) begin
        w_next_state = S_WAIT;
        w_next_cnt   = 16'd0;
      end
    endcase
    case (w_next_state)
      S_RESP:  w_next_tx = r_resp[39:32];
      S_TOKEN: w_next_tx = 8'hFE;
      S_DATA:  w_next_tx = r_mem_byte;
      default: w_next_tx = 8'hFF;
    endcase
  end

  // Command decode: response bytes and card flag updates for the completed frame
  always_comb begin
    w_dec_resp  = {w_r1, 32'hFFFF_FFFF};
    w_dec_len   = 3'd1;
    w_dec_data  = 1'b0;
    w_dec_idle  = r_idle_flag;
    w_dec_app   = 1'b0;
    w_dec_ready = card_ready_o;
    w_dec_acnt  = r_acmd41_cnt;
    case (r_index)
      6'd0: begin
        w_dec_resp  = {8'h01, 32'hFFFF_FFFF};
        w_dec_idle  = 1'b1;
        w_dec_ready = 1'b0;
        w_dec_acnt  = 8'd0;
      end
      6'd8: begin
        w_dec_resp = {w_r1, 8'h00, 8'h00, 4'h0, r_arg[11:8], r_arg[7:0]};
        w_dec_len  = 3'd5;
      end
      6'd55: w_dec_app = 1'b1;
      6'd41: begin
        if (!r_app_flag) begin
          w_dec_resp = {(8'h04 | w_r1), 32'hFFFF_FFFF};
        end else if (r_acmd41_cnt < LP_BUSY) begin
          w_dec_resp = {8'h01, 32'hFFFF_FFFF};
          w_dec_acnt = r_acmd41_cnt + 8'd1;
        end else begin
          w_dec_resp  = {8'h00, 32'hFFFF_FFFF};
          w_dec_idle  = 1'b0;
          w_dec_ready = 1'b1;
        end
      end
      6'd58: begin
        w_dec_resp = {w_r1, OCR};
        w_dec_len  = 3'd5;
      end
      6'd17: begin
        if (r_idle_flag) begin
          w_dec_resp = {8'h05, 32'hFFFF_FFFF};
        end else begin
          w_dec_resp = {8'h00, 32'hFFFF_FFFF};
          w_dec_data = 1'b1;
        end
      end
      default: w_dec_resp = {(8'h04 | w_r1), 32'hFFFF_FFFF};
    endcase
  end

  // SPI shifting, byte-boundary sequencing, decode commit and memory prefetch
  always_ff @(posedge sdr_clk_i or negedge sdr_rst_ni) begin
    if (!sdr_rst_ni) begin
      spi_miso_o     <= 1'b1;
      mem_rd_o       <= 1'b0;
      mem_addr_o     <= 32'd0;
      cmd_valid_o    <= 1'b0;
      cmd_index_o    <= 6'd0;
      cmd_arg_o      <= 32'd0;
      card_ready_o   <= 1'b0;
      r_bit_cnt      <= 3'd0;
      r_rx_shift     <= 7'd0;
      r_tx_shift     <= 8'hFF;
      r_state        <= S_WAIT;
      r_cnt          <= 16'd0;
      r_index        <= 6'd0;
      r_arg          <= 32'd0;
      r_resp         <= 40'hFF_FFFF_FFFF;
      r_resp_len     <= 3'd1;
      r_data_pending <= 1'b0;
      r_idle_flag    <= 1'b1;
      r_app_flag     <= 1'b0;
      r_acmd41_cnt   <= 8'd0;
      r_fetch_req    <= 1'b0;
      r_fetch_addr   <= 32'd0;
      r_rd_dly       <= 1'b0;
      r_mem_byte     <= 8'hFF;
    end else begin
      cmd_valid_o <= 1'b0;
      mem_rd_o    <= 1'b0;
      r_rd_dly    <= mem_rd_o;
      if (r_rd_dly) r_mem_byte <= mem_data_i;
      if (r_fetch_req) begin
        mem_rd_o     <= 1'b1;
        mem_addr_o   <= r_fetch_addr;
        r_fetch_addr <= r_fetch_addr + 32'd1;
        r_fetch_req  <= 1'b0;
      end

      if (!w_cs_active) begin
        r_bit_cnt   <= 3'd0;
        r_state     <= S_WAIT;
        r_cnt       <= 16'd0;
        r_tx_shift  <= 8'hFF;
        spi_miso_o  <= 1'b1;
        r_fetch_req <= 1'b0;
      end else begin
        if (w_sck_fall) begin
          spi_miso_o <= r_tx_shift[7];
          r_tx_shift <= {r_tx_shift[6:0], 1'b1};
        end
        if (w_sck_rise) begin
          r_rx_shift <= w_rx_byte[6:0];
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_tx_shift <= w_next_tx;
            if (w_next_state == S_RESP) r_resp <= {r_resp[31:0], 8'hFF};
            case (r_state)
              S_WAIT: if (w_start) r_index <= w_rx_byte[5:0];
              S_CMD: begin
                if (r_cnt < 16'd4) begin
                  r_arg <= {r_arg[23:0], w_rx_byte};
                end else begin
                  // CRC byte: the frame is complete, commit its effects
                  cmd_valid_o    <= 1'b1;
                  cmd_index_o    <= r_index;
                  cmd_arg_o      <= r_arg;
                  r_resp         <= w_dec_resp;
                  r_resp_len     <= w_dec_len;
                  r_data_pending <= w_dec_data;
                  r_idle_flag    <= w_dec_idle;
                  r_app_flag     <= w_dec_app;
                  card_ready_o   <= w_dec_ready;
                  r_acmd41_cnt   <= w_dec_acnt;
                  r_fetch_addr   <= r_arg;
                end
              end
              default: ;
            endcase
            // Fetch one byte ahead: byte 0 on entering NAC, byte k+1 while byte k loads
            if ((r_state == S_RESP && w_next_state == S_NAC) ||
                (w_next_state == S_DATA && w_next_cnt != LP_BLOCK_LAST)) begin
              r_fetch_req <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
